// File: rtl/dcache_line_port.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_line_port
//  Purpose  : Data-side initiator for the 4-word line memory port. Holds a
//             single line buffer (tag + 4 x 16-bit words), serves load hits
//             locally, fetches the whole line on a miss and writes stores back
//             as a read-modify-write of the complete line.
//  Ports    :
//    clk, reset          clock; asynchronous active-high reset
//    cpu_req/cpu_we      request valid / 1=store 0=load
//    cpu_addr/cpu_wdata  word address / store data
//    cpu_ready           idle, able to accept a request
//    cpu_ack/cpu_rdata   one-cycle completion pulse / load data
//    mem_read/mem_write  line fetch / line store pulses
//    mem_addr            line address {tag, 2'b00}
//    mem_data            64-bit bidirectional line bus, word k at [16k+15:16k]
//    hit_count/miss_count (only with DCACHE_STATS_EN) saturating counters
//  Options  : DCACHE_STATS_EN adds the hit/miss statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module dcache_line_port #(
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 3,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [63:0]       mem_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MERGE = 3'd2,
        S_STORE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam int c_CNT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_READ_CNT  = c_CNT_W'(READ_LAT);
    localparam logic [c_CNT_W-1:0] c_WRITE_CNT = c_CNT_W'(WRITE_LAT);

    state_t               r_state;
    state_t               w_stateNext;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_valid;
    logic [ADDR_W-3:0]    r_tag;
    logic [3:0][15:0]     r_line;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [15:0]          r_wdata;
    logic [15:0]          r_rdata;

    logic                 w_accept;
    logic                 w_hit;
    logic                 w_fetchDone;
    logic                 w_storeDone;
    logic [15:0]          w_fetchWord;

    assign w_accept    = cpu_req && (r_state == S_IDLE);
    assign w_hit       = r_valid && (cpu_addr[ADDR_W-1:2] == r_tag);
    // r_cnt counts edges spent in the current state; the edge after the
    // first cycle is the one the memory samples the request pulse on.
    assign w_fetchDone = (r_state == S_FETCH) && (r_cnt == c_READ_CNT);
    assign w_storeDone = (r_state == S_STORE) && (r_cnt == c_WRITE_CNT);
    assign w_fetchWord = mem_data[{r_addr[1:0], 4'b0000} +: 16];

    // The bus is only ever driven while writing a line back.
    assign mem_data  = (r_state == S_STORE) ? r_line : {64{1'bz}};
    assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign cpu_rdata = r_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_stateNext != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_FETCH) || (r_state == S_STORE)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        cpu_ready   = 1'b0;
        cpu_ack     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu_ready = 1'b1;
                if (w_accept) begin
                    if (!w_hit)      w_stateNext = S_FETCH;
                    else if (cpu_we) w_stateNext = S_MERGE;
                    else             w_stateNext = S_RESP;
                end
            end
            S_FETCH: begin
                mem_read = (r_cnt == '0);
                if (w_fetchDone) w_stateNext = r_we ? S_MERGE : S_RESP;
            end
            S_MERGE: begin
                w_stateNext = S_STORE;
            end
            S_STORE: begin
                mem_write = (r_cnt == '0);
                if (w_storeDone) w_stateNext = S_RESP;
            end
            S_RESP: begin
                cpu_ack     = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, line buffer and load data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= cpu_addr;
                r_we    <= cpu_we;
                r_wdata <= cpu_wdata;
                // Load hit answers next cycle, so the word is picked here.
                if (w_hit && !cpu_we) r_rdata <= r_line[cpu_addr[1:0]];
            end
            if (w_fetchDone) begin
                r_line  <= mem_data;
                r_tag   <= r_addr[ADDR_W-1:2];
                r_valid <= 1'b1;
                if (!r_we) r_rdata <= w_fetchWord;
            end
            if (r_state == S_MERGE) begin
                r_line[r_addr[1:0]] <= r_wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hitCount;
    logic [15:0] r_missCount;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_hitCount != 16'hFFFF) r_hitCount <= r_hitCount + 16'd1;
            end else begin
                if (r_missCount != 16'hFFFF) r_missCount <= r_missCount + 16'd1;
            end
        end
    end

    assign hit_count  = r_hitCount;
    assign miss_count = r_missCount;
`endif

endmodule
`default_nettype wire
